// File: rtl/fpu_pkg.sv
// Shared FPU constants and small combinational helpers for the divide pipeline.
package fpu_pkg;

  // Rounding-mode encodings carried on rm.
  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RDN = 2'd2;
  localparam logic [1:0] RM_RUP = 2'd3;

  // Canonical quiet NaN and magnitude patterns (sign bit excluded).
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;
  localparam logic [30:0] MAG_INF    = 31'h7F80_0000;
  localparam logic [30:0] MAG_MAXFIN = 31'h7F7F_FFFF;

  // Bit positions inside the 5-bit flags vector {invalid, dz, overflow, underflow, inexact}.
  localparam int FLAG_INV = 4;
  localparam int FLAG_DZ  = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_NX  = 0;

  localparam logic [9:0] EXP_BIAS = 10'd127;
  localparam logic [9:0] EXP_MAX  = 10'd255;

  // Round-increment decision from mode, sign, guard, sticky and mantissa LSB.
  function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                     input logic g, input logic s, input logic lsb);
    logic inc;
    case (rm)
      RM_RNE:  inc = g & (s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  // Overflowed result: infinity or largest finite depending on mode and sign.
  function automatic logic [31:0] ovf_result(input logic [1:0] rm, input logic sign);
    logic [31:0] res;
    case (rm)
      RM_RNE:  res = {sign, MAG_INF};
      RM_RTZ:  res = {sign, MAG_MAXFIN};
      RM_RDN:  res = sign ? {1'b1, MAG_INF} : {1'b0, MAG_MAXFIN};
      RM_RUP:  res = sign ? {1'b1, MAG_MAXFIN} : {1'b0, MAG_INF};
      default: res = {sign, MAG_INF};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fdiv_round_pack_rshift_sticky.sv
// 26-bit logical right shift with saturating amount; every bit shifted out
// is ORed into a sticky output so rounding still sees the lost precision.
module fdiv_rshift_sticky (
  input  logic [25:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic [25:0] o_data,
  output logic        o_sticky
);

  logic [4:0]  w_amt;
  logic [25:0] w_mask;

  // Saturate the amount at 26 (everything out) and collect the discarded bits.
  always_comb begin
    w_amt = 5'd0;
    if (i_shamt > 5'd26) begin
      w_amt = 5'd26;
    end else begin
      w_amt = i_shamt;
    end
    o_data   = i_data >> w_amt;
    w_mask   = ~(26'h3FF_FFFF << w_amt);
    o_sticky = |(i_data & w_mask);
  end

endmodule

// File: rtl/fdiv_round_pack.sv
// Normalize / round / pack stage of the binary32 divider. Stage 1 normalizes
// the quotient and denormalizes tiny results; stage 2 rounds, detects
// overflow, applies special classes and registers the packed result.
module fdiv_round_pack
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        ena,
  input  logic        in_valid,
  input  logic [31:0] q,
  input  logic        sign,
  input  logic [9:0]  exp,
  input  logic [1:0]  rm,
  input  logic        s_nan,
  input  logic        s_inf,
  input  logic        s_zero,
  input  logic        s_inv,
  input  logic        s_dz,
  output logic [31:0] result,
  output logic [4:0]  flags,
  output logic        out_valid
);

  // ---------------- stage 1: normalize ----------------
  logic [23:0]        w_m;
  logic               w_g;
  logic               w_s;
  logic signed [10:0] w_e;
  logic               w_tiny;
  logic signed [10:0] w_diff;
  logic [4:0]         w_shamt;
  logic [25:0]        w_sh_data;
  logic               w_sh_sticky;
  logic [23:0]        w_n_m;
  logic               w_n_g;
  logic               w_n_s;
  logic [9:0]         w_n_e;

  // Select the 24-bit significand window depending on the integer bit.
  always_comb begin
    w_m = 24'd0;
    w_g = 1'b0;
    w_s = 1'b0;
    w_e = 11'sd0;
    if (q[31]) begin
      w_m = q[31:8];
      w_g = q[7];
      w_s = |q[6:0];
      w_e = {exp[9], exp};
    end else begin
      w_m = q[30:7];
      w_g = q[6];
      w_s = |q[5:0];
      w_e = {exp[9], exp} - 11'sd1;
    end
  end

  // Tiny results need a right shift of 1-e; clamp to 5 bits (shifter caps at 26).
  always_comb begin
    w_tiny  = (w_e <= 11'sd0);
    w_diff  = 11'sd1 - w_e;
    w_shamt = 5'd0;
    if (!w_tiny) begin
      w_shamt = 5'd0;
    end else if (w_diff > 11'sd31) begin
      w_shamt = 5'd31;
    end else begin
      w_shamt = w_diff[4:0];
    end
  end

  fdiv_rshift_sticky u_rshift (
    .i_data   ({w_m, w_g, w_s}),
    .i_shamt  (w_shamt),
    .o_data   (w_sh_data),
    .o_sticky (w_sh_sticky)
  );

  // Choose the denormalized operand for tiny results, else pass through.
  always_comb begin
    w_n_m = w_m;
    w_n_g = w_g;
    w_n_s = w_s;
    w_n_e = w_e[9:0];
    if (w_tiny) begin
      w_n_m = w_sh_data[25:2];
      w_n_g = w_sh_data[1];
      w_n_s = w_sh_data[0] | w_sh_sticky;
      w_n_e = 10'd0;
    end else begin
      w_n_m = w_m;
      w_n_g = w_g;
      w_n_s = w_s;
      w_n_e = w_e[9:0];
    end
  end

  logic        r_s1_valid;
  logic        r_s1_sign;
  logic [1:0]  r_s1_rm;
  logic [23:0] r_s1_m;
  logic        r_s1_g;
  logic        r_s1_s;
  logic [9:0]  r_s1_e;
  logic        r_s1_tiny;
  logic        r_s1_nan;
  logic        r_s1_inf;
  logic        r_s1_zero;
  logic        r_s1_inv;
  logic        r_s1_dz;

  // Stage-1 boundary register; holds while ena is low.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_rm    <= 2'd0;
      r_s1_m     <= 24'd0;
      r_s1_g     <= 1'b0;
      r_s1_s     <= 1'b0;
      r_s1_e     <= 10'd0;
      r_s1_tiny  <= 1'b0;
      r_s1_nan   <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inv   <= 1'b0;
      r_s1_dz    <= 1'b0;
    end else if (ena) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= sign;
      r_s1_rm    <= rm;
      r_s1_m     <= w_n_m;
      r_s1_g     <= w_n_g;
      r_s1_s     <= w_n_s;
      r_s1_e     <= w_n_e;
      r_s1_tiny  <= w_tiny;
      r_s1_nan   <= s_nan;
      r_s1_inf   <= s_inf;
      r_s1_zero  <= s_zero;
      r_s1_inv   <= s_inv;
      r_s1_dz    <= s_dz;
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic        w_inc;
  logic [24:0] w_sum;
  logic [23:0] w_mr;
  logic [9:0]  w_er;
  logic        w_nx;
  logic        w_ovf;
  logic [31:0] w_result;
  logic [4:0]  w_flags;

  // Round the significand; a carry renormalizes, a subnormal reaching the
  // hidden bit becomes the smallest normal.
  always_comb begin
    w_inc = round_inc(r_s1_rm, r_s1_sign, r_s1_g, r_s1_s, r_s1_m[0]);
    w_sum = {1'b0, r_s1_m} + {24'd0, w_inc};
    w_mr  = 24'd0;
    w_er  = 10'd0;
    if (w_sum[24]) begin
      w_mr = 24'h80_0000;
      w_er = r_s1_e + 10'd1;
    end else if ((r_s1_e == 10'd0) && w_sum[23]) begin
      w_mr = w_sum[23:0];
      w_er = 10'd1;
    end else begin
      w_mr = w_sum[23:0];
      w_er = r_s1_e;
    end
    w_nx  = r_s1_g | r_s1_s;
    w_ovf = (w_er >= EXP_MAX);
  end

  // Special classes override the arithmetic result and its flags.
  always_comb begin
    w_result = 32'd0;
    w_flags  = 5'd0;
    if (r_s1_nan) begin
      w_result           = QNAN;
      w_flags[FLAG_INV]  = r_s1_inv;
    end else if (r_s1_inf) begin
      w_result           = {r_s1_sign, MAG_INF};
      w_flags[FLAG_DZ]   = r_s1_dz;
    end else if (r_s1_zero) begin
      w_result           = {r_s1_sign, 31'd0};
    end else if (w_ovf) begin
      w_result           = ovf_result(r_s1_rm, r_s1_sign);
      w_flags[FLAG_OVF]  = 1'b1;
      w_flags[FLAG_NX]   = 1'b1;
    end else begin
      w_result           = {r_s1_sign, w_er[7:0], w_mr[22:0]};
      w_flags[FLAG_UNF]  = r_s1_tiny & w_nx;
      w_flags[FLAG_NX]   = w_nx;
    end
  end

  // Output registers; hold while ena is low.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      result    <= 32'd0;
      flags     <= 5'd0;
      out_valid <= 1'b0;
    end else if (ena) begin
      result    <= w_result;
      flags     <= w_flags;
      out_valid <= r_s1_valid;
    end
  end

endmodule

// File: tb/tb_fdiv_round_pack.sv
// Directed-vector bench for fdiv_round_pack with hand-computed expectations.
module tb_fdiv_round_pack;

  logic        clk;
  logic        clrn;
  logic        ena;
  logic        in_valid;
  logic [31:0] q;
  logic        sign;
  logic [9:0]  exp;
  logic [1:0]  rm;
  logic        s_nan, s_inf, s_zero, s_inv, s_dz;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  fdiv_round_pack dut (
    .clk(clk), .clrn(clrn), .ena(ena), .in_valid(in_valid), .q(q),
    .sign(sign), .exp(exp), .rm(rm), .s_nan(s_nan), .s_inf(s_inf),
    .s_zero(s_zero), .s_inv(s_inv), .s_dz(s_dz), .result(result),
    .flags(flags), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // cls = {nan, inf, zero, inv, dz}
  task automatic run_op(input string tag, input logic [31:0] tq, input logic [9:0] te,
                        input logic ts, input logic [1:0] trm, input logic [4:0] cls,
                        input logic [31:0] er, input logic [4:0] ef);
    @(negedge clk);
    ena = 1'b1; in_valid = 1'b1; q = tq; exp = te; sign = ts; rm = trm;
    {s_nan, s_inf, s_zero, s_inv, s_dz} = cls;
    @(posedge clk); #1;
    chk({tag, "_vld_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"}, {27'd0, flags}, {27'd0, ef});
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
  endtask

  logic [31:0] held_res;

  initial begin
    clrn = 1'b0; ena = 1'b1; in_valid = 1'b0; q = 32'd0; sign = 1'b0;
    exp = 10'd0; rm = 2'd0; {s_nan, s_inf, s_zero, s_inv, s_dz} = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", result, 32'd0);
    chk("rst_flg", {27'd0, flags}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk); clrn = 1'b1;
    @(posedge clk);

    run_op("exact",    32'hC000_0000, 10'd127, 1'b0, 2'd0, 5'b00000, 32'h3FC0_0000, 5'b00000);
    run_op("rne_3rd",  32'h5555_5555, 10'd127, 1'b0, 2'd0, 5'b00000, 32'h3F2A_AAAB, 5'b00001);
    run_op("rtz_3rd",  32'h5555_5555, 10'd127, 1'b0, 2'd1, 5'b00000, 32'h3F2A_AAAA, 5'b00001);
    run_op("carry",    32'hFFFF_FF80, 10'd127, 1'b0, 2'd0, 5'b00000, 32'h4000_0000, 5'b00001);
    run_op("ovf_rne",  32'h8000_0000, 10'd300, 1'b0, 2'd0, 5'b00000, 32'h7F80_0000, 5'b00101);
    run_op("ovf_rtz",  32'h8000_0000, 10'd300, 1'b0, 2'd1, 5'b00000, 32'h7F7F_FFFF, 5'b00101);
    run_op("ovf_rupn", 32'h8000_0000, 10'd300, 1'b1, 2'd3, 5'b00000, 32'hFF7F_FFFF, 5'b00101);
    run_op("ovf_rdnn", 32'h8000_0000, 10'd300, 1'b1, 2'd2, 5'b00000, 32'hFF80_0000, 5'b00101);
    run_op("sub_ex",   32'h8000_0000, 10'd0,   1'b0, 2'd0, 5'b00000, 32'h0040_0000, 5'b00000);
    run_op("sub_rne",  32'h8000_0000, 10'h3E2, 1'b0, 2'd0, 5'b00000, 32'h0000_0000, 5'b00011);
    run_op("sub_rup",  32'h8000_0000, 10'h3E2, 1'b0, 2'd3, 5'b00000, 32'h0000_0001, 5'b00011);
    run_op("inf_dz",   32'h8000_0000, 10'd127, 1'b1, 2'd0, 5'b01001, 32'hFF80_0000, 5'b01000);
    run_op("zero_n",   32'h8000_0000, 10'd127, 1'b1, 2'd0, 5'b00100, 32'h8000_0000, 5'b00000);

    // NaN enters stage 1, then the pipe stalls with it in flight.
    @(negedge clk);
    in_valid = 1'b1; q = 32'h8000_0000; exp = 10'd127; sign = 1'b0; rm = 2'd0;
    {s_nan, s_inf, s_zero, s_inv, s_dz} = 5'b10010;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0; in_valid = 1'b0; {s_nan, s_inf, s_zero, s_inv, s_dz} = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall1_vld", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk); ena = 1'b1;
    @(posedge clk); #1;
    chk("nan_res", result, 32'h7FC0_0000);
    chk("nan_flg", {27'd0, flags}, 32'h0000_0010);
    chk("nan_vld", {31'd0, out_valid}, 32'd1);
    held_res = result;
    @(negedge clk); ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall2_res", result, 32'h7FC0_0000);
      chk("stall2_vld", {31'd0, out_valid}, 32'd1);
    end
    chk("stall2_same", result, held_res);

    // Load a new op into stage 1, then reset drops it.
    @(negedge clk);
    ena = 1'b1; in_valid = 1'b1; q = 32'hC000_0000; exp = 10'd127;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; clrn = 1'b0;
    #1;
    chk("mid_rst_res", result, 32'd0);
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk); clrn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("post_rst_res", result, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
